transpose_drain_fifo: RTL and testbench
=======================================

# transpose_drain_fifo

Credit-managed output buffer placed directly downstream of the E×E transpose stage in the FHE interconnect datapath. The transpose stage emits each block as a burst of ELEMS consecutive beats and has no backpressure input, so this block captures every beat unconditionally and re-presents the stream on a valid/ready interface. It also drives a block-granular credit (`block_ready`) so the upstream issuer starts a new ELEMS-beat block only when the whole block is guaranteed to fit.

## Interface
- `DATA_SIZE`, default `FSIZE`: width of one element.
- `ELEMS`, default `E`: elements per beat and beats per block.
- `BLOCKS`, default 2: buffer capacity in blocks. `DEPTH = BLOCKS*ELEMS` beats; `DEPTH` need not be a power of two.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, synchronous, active-low.
- `in_data`, in, DATA_SIZE*ELEMS: beat from the transpose stage; element i is at `[DATA_SIZE*i +: DATA_SIZE]`.
- `in_valid`, in, 1: beat present. No ready is returned; the beat must be taken.
- `in_last`, in, 1: stream-last marker, stored with the beat.
- `block_issue`, in, 1: one-cycle pulse from the upstream issuer that reserves ELEMS entries.
- `block_ready`, out, 1: at least ELEMS unreserved free entries exist.
- `out_data`, out, DATA_SIZE*ELEMS: head beat.
- `out_valid`, out, 1: head beat valid.
- `out_last`, out, 1: `in_last` stored with the head beat.
- `out_ready`, in, 1: downstream accepts the head beat.
- `level`, out, $clog2(DEPTH+1): stored beat count.
- `overflow`, out, 1: sticky error flag.

## Operation
- **Storage:** `DEPTH` entries, each `{last, data}`, with `wr_ptr`, `rd_ptr` and `count`. Each pointer wraps from `DEPTH-1` to 0.
- **Push:** `push = in_valid && (count < DEPTH || pop)`.
- **Pop:** `pop = out_valid && out_ready`.
- **Count update:** `count_next = count + push - pop`.
- **Dropped beat:** if `in_valid` arrives while `count == DEPTH` and there is no pop, the beat is discarded, `overflow` is set, and the pointers and count are unchanged.
- **Outputs:** `out_valid = (count != 0)`. `out_data` and `out_last` are read combinationally from `mem[rd_ptr]`, i.e. first-word fall-through from the storage array.
- **Reservation counter `pending`:** range 0..DEPTH.
  - `pending_next = pending + (issue_ok ? ELEMS : 0) - (push && (pending != 0 || issue_ok) ? 1 : 0)`.
  - `issue_ok = block_issue && block_ready`.
- **Rejected issue:** `block_issue` while `block_ready == 0` is ignored for reservation purposes and sets `overflow`.
- **Credit:** `block_ready = (DEPTH - count - pending) >= ELEMS`. It is computed from registers only; a pop in cycle t first raises the credit in cycle t+1.
- **Beats without a reservation:** a beat arriving with `pending == 0` is still stored if there is space; it is not an error.
- **Overflow flag:** `overflow` clears only on reset.
- **Width rule:** all arithmetic uses widths holding 0..DEPTH+ELEMS; there is no wrap in `pending` or `count`.

## Timing
- **Reset** (`rstn == 0` at a clk edge) clears `wr_ptr`, `rd_ptr`, `count`, `pending` and `overflow`. Storage contents are not reset.
- **Outputs after reset:**
  - `out_valid = 0`, `level = 0`, `overflow = 0`.
  - `block_ready = 1` (requires `DEPTH >= ELEMS`, which holds since `BLOCKS >= 1`).
  - `out_data` and `out_last` are don't-care.
- **Reset mid-operation:** all stored beats and reservations are discarded; the next cycle looks like power-up.
- **Latency:** a beat written at edge t appears on `out_valid`/`out_data` after edge t (one cycle). There is no same-cycle bypass from an empty buffer.
- **Simultaneous push and pop at full:** the push is accepted and `count` stays at `DEPTH`.
- **Simultaneous push and pop at empty:** cannot occur, since pop requires `out_valid`.
- **Holding:** `out_valid` with `out_ready == 0` holds `out_data` and `out_last` stable.
- **Sustained rate:** one beat in and one beat out per cycle.
- **`level`** is the registered `count`.

## Test plan
Parameters: ELEMS=4, BLOCKS=2, DEPTH=8, DATA_SIZE=8.

1. **Reset values:** drive reset, then release it -> `out_valid=0`, `level=0`, `block_ready=1`, `overflow=0`.
2. **Single block pass-through:** pulse `block_issue`, then 4 beats 0x..01..04 with `in_last` on beat 4, `out_ready=1` -> `block_ready` stays 1 (pending=4, free=8). Outputs are 01..04, each one cycle after its input, with `out_last` only on 04. Final `level=0`.
3. **Credit exhaustion:** `out_ready=0`, issue two blocks and push 8 beats -> `block_ready` drops to 0 the cycle after the second issue. `level=8`. A third `block_issue` sets `overflow=1`.
4. **Full with simultaneous push and pop:** at `level=8`, assert `in_valid` and `out_ready` together for 3 cycles -> no drop, `level` stays 8, `overflow` unchanged, output order preserved.
5. **Overflow drop:** at `level=8`, `out_ready=0`, push beat 0xAA -> `overflow=1`, `level=8`. Draining yields the original 8 beats without 0xAA.
6. **Wrap and mid-reset:**
   - Stream 20 beats with random `out_ready` -> correct order across pointer wrap.
   - Assert `rstn=0` with `level=5` -> the next cycle shows `level=0`, `out_valid=0`, `block_ready=1`.

Source files
------------

// File: rtl/transpose_drain_fifo.sv
// transpose_drain_fifo: output buffer behind the transpose stage.
// Every beat from the transpose stage is captured unconditionally and
// re-presented on a valid/ready interface with first-word fall-through.
// A block-granular credit (block_ready) lets the upstream issuer start an
// ELEMS-beat block only when the whole block is guaranteed to fit.
module transpose_drain_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int ELEMS     = 4,
    parameter int BLOCKS    = 2,
    localparam int DEPTH    = BLOCKS * ELEMS,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_SIZE*ELEMS-1:0]   in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic                         block_issue,
    output logic                         block_ready,
    output logic [DATA_SIZE*ELEMS-1:0]   out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic [LW-1:0]                level,
    output logic                         overflow
);

    // Counter width covers 0..DEPTH+ELEMS so no intermediate sum can wrap.
    localparam int CW = $clog2(DEPTH + ELEMS + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = DATA_SIZE * ELEMS;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ELEMS_C = CW'(ELEMS);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [BW:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  pending;

    logic           push;
    logic           pop;
    logic           issue_ok;
    logic           consume;
    logic [CW-1:0]  count_next;
    logic [CW-1:0]  pending_next;

    // Handshake decode, credit and next-state arithmetic for the counters.
    always_comb begin
        out_valid    = (count != '0);
        pop          = out_valid && out_ready;
        push         = in_valid && ((count < DEPTH_C) || pop);
        // count + pending never exceeds DEPTH, so the sum form avoids underflow.
        block_ready  = (count + pending + ELEMS_C) <= DEPTH_C;
        issue_ok     = block_issue && block_ready;
        consume      = push && ((pending != '0) || issue_ok);
        count_next   = count + CW'(push) - CW'(pop);
        pending_next = pending + (issue_ok ? ELEMS_C : '0) - CW'(consume);
    end

    // First-word fall-through: the head entry is read straight from storage.
    always_comb begin
        out_data = mem[rd_ptr][BW-1:0];
        out_last = mem[rd_ptr][BW];
    end

    assign level = count[LW-1:0];

    // Storage array; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // Pointers, occupancy, reservations and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            end
            count   <= count_next;
            pending <= pending_next;
            if ((in_valid && !push) || (block_issue && !block_ready)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_transpose_drain_fifo.sv
// tb_transpose_drain_fifo: randomized self-checking bench for
// transpose_drain_fifo with ELEMS=4, BLOCKS=2, DATA_SIZE=8 (DEPTH=8).
// A queue-based reference model tracks stored beats, reservations and the
// overflow flag; DUT outputs are compared one time unit after each edge.
module tb_transpose_drain_fifo;

    localparam int DS    = 8;
    localparam int EL    = 4;
    localparam int BL    = 2;
    localparam int DEPTH = BL * EL;
    localparam int BW    = DS * EL;

    logic          clk = 1'b0;
    logic          rstn;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          block_issue;
    logic          block_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [3:0]    level;
    logic          overflow;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic [BW:0] q[$];
    int          pending = 0;
    bit          ovf     = 1'b0;

    transpose_drain_fifo #(
        .DATA_SIZE (DS),
        .ELEMS     (EL),
        .BLOCKS    (BL)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .block_issue (block_issue),
        .block_ready (block_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelCredit();
        return (DEPTH - q.size() - pending) >= EL;
    endfunction

    // Compares every visible output against the model's current state.
    task automatic checkAll();
        checkOutput("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            checkOutput("out_data", out_data, q[0][BW-1:0]);
            checkOutput("out_last", out_last, q[0][BW]);
        end
        checkOutput("level", level, q.size());
        checkOutput("block_ready", block_ready, modelCredit());
        checkOutput("overflow", overflow, ovf);
    endtask

    // Advances the model by one clock using the currently driven inputs.
    task automatic modelStep();
        bit pop, accept, credit, issueOk;
        if (!rstn) begin
            q.delete();
            pending = 0;
            ovf     = 1'b0;
            return;
        end
        pop     = (q.size() != 0) && out_ready;
        accept  = in_valid && (q.size() < DEPTH || pop);
        credit  = modelCredit();
        issueOk = block_issue && credit;
        if (in_valid && !accept) ovf = 1'b1;
        if (block_issue && !credit) ovf = 1'b1;
        if (accept && (pending != 0 || issueOk)) pending = pending - 1;
        if (issueOk) pending = pending + EL;
        if (pop) void'(q.pop_front());
        if (accept) q.push_back({in_last, in_data});
    endtask

    // Drives one cycle of inputs, checks outputs, then advances one edge.
    task automatic applyStimulus(input logic iv, input logic [BW-1:0] d,
                                 input logic lst, input logic iss,
                                 input logic ordy, input logic rn);
        in_valid    = iv;
        in_data     = d;
        in_last     = lst;
        block_issue = iss;
        out_ready   = ordy;
        rstn        = rn;
        checkAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, $urandom, 1'b0, 1'b0, ordy, 1'b1);
    endtask

    initial begin
        int accepted;
        int guard;
        logic iv;

        // Power-up reset: the model starts empty, so outputs are not yet compared.
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        block_issue = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // 1: reset values
        checkOutput("rst out_valid", out_valid, 1'b0);
        checkOutput("rst level", level, 0);
        checkOutput("rst block_ready", block_ready, 1'b1);
        checkOutput("rst overflow", overflow, 1'b0);

        // 2: single block pass-through
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 32'h01010101 * k, k == 4, 1'b0, 1'b1, 1'b1);
            checkOutput("pass block_ready", block_ready, 1'b1);
        end
        repeat (2) idle(1'b1);
        checkOutput("pass final level", level, 0);

        // 3: credit exhaustion
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("credit after 1st issue", block_ready, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("credit after 2nd issue", block_ready, 1'b0);
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, $urandom, k % 4 == 3, 1'b0, 1'b0, 1'b1);
        checkOutput("full level", level, 8);
        checkOutput("full overflow clear", overflow, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("rejected issue overflow", overflow, 1'b1);

        // 4: full with simultaneous push and pop
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("full push+pop level", level, 8);
        end

        // 5: overflow drop then drain
        applyStimulus(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("drop level", level, 8);
        checkOutput("drop overflow", overflow, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("drain no AA", out_data == 32'hAAAAAAAA, 1'b0);
            idle(1'b1);
        end
        checkOutput("drained level", level, 0);

        // 6: clean restart, random stream across wrap, then mid-stream reset
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart overflow", overflow, 1'b0);
        accepted = 0;
        guard    = 0;
        while (accepted < 20 && guard < 400) begin
            iv = ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
            if (iv) accepted++;
            applyStimulus(iv, $urandom, accepted % 4 == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 1), 1'b1);
            guard++;
        end
        checkOutput("stream completed", accepted, 20);
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            idle($urandom_range(0, 1));
            guard++;
        end
        checkOutput("stream drained", level, 0);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pre-reset level", level, 5);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid-reset level", level, 0);
        checkOutput("mid-reset out_valid", out_valid, 1'b0);
        checkOutput("mid-reset block_ready", block_ready, 1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
